// File: rtl/ptt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptt_pkg
// Description : Shared types, default sizes and helpers for photon_timetagger.
// Revision    : 1.0 - initial release
// ============================================================================
package ptt_pkg;

    localparam int TS_W_DEF        = 32;
    localparam int FIFO_AW_DEF     = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEAD_CYC_DEF    = 4;
    localparam int DROP_W_DEF      = 16;

    typedef logic [TS_W_DEF-1:0]   ts_t;
    typedef logic [DROP_W_DEF-1:0] drop_t;

    // Width of a down-counter able to hold the value cyc (at least 1 bit).
    function automatic int dead_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptt_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ptt_tag_fifo
// Description : Count-free synchronous FIFO, 2^AW entries, registered
//               valid/ready output with first-word fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module ptt_tag_fifo
    import ptt_pkg::*;
#(
    parameter int WIDTH = TS_W_DEF,
    parameter int AW    = FIFO_AW_DEF
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_v,
    input  logic             out_r
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             v_q, v_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push_ok, pop;

    // The head stays in memory until popped, so the output register is only a
    // copy and never adds capacity. Validity uses the pre-write pointer, which
    // gives one cycle of latency from push to visible word.
    always_comb begin
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push_ok = push && !full;
        pop     = v_q && out_r;
        wr_d    = wr_q + {{AW{1'b0}}, push_ok};
        rd_d    = rd_q + {{AW{1'b0}}, pop};
        v_d     = (wr_q != rd_d);
        data_d  = v_d ? mem_q[rd_d[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_q   <= '0;
            rd_q   <= '0;
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_v    = v_q;
    assign out_data = data_q;

endmodule
`default_nettype wire

// File: rtl/photon_timetagger.sv
`default_nettype none
// ============================================================================
// Module      : photon_timetagger
// Description : Two-channel photon time-tagger: free-running counter, input
//               synchronisers, edge tagging, per-channel FIFOs, drop counters.
//               Optional per-channel dead time when PTT_DEADTIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module photon_timetagger
    import ptt_pkg::*;
#(
    parameter int TS_W        = TS_W_DEF,
    parameter int FIFO_AW     = FIFO_AW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEAD_CYC    = DEAD_CYC_DEF,
    parameter int DROP_W      = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              det1,
    input  logic              det2,
    input  logic              enable,
    output logic [TS_W-1:0]   ts1,
    output logic              ts1_v,
    input  logic              ts1_r,
    output logic [TS_W-1:0]   ts2,
    output logic              ts2_v,
    input  logic              ts2_r,
    output logic [DROP_W-1:0] drop1,
    output logic [DROP_W-1:0] drop2,
    output logic              wrap
);

    logic [TS_W-1:0]             cnt_q, cnt_d;
    logic                        wrap_q, wrap_d;
    logic [TS_W-1:0]             tag_w;
    logic [1:0]                  det_w, rdy_w, v_w;
    logic [1:0][TS_W-1:0]        ts_w;
    logic [1:0][DROP_W-1:0]      drop_w;

    assign det_w = {det2, det1};
    assign rdy_w = {ts2_r, ts1_r};

    always_comb begin
        cnt_d  = cnt_q + TS_W'(1);
        wrap_d = &cnt_q;
        // An edge seen now was first captured SYNC_STAGES cycles ago.
        tag_w  = cnt_q - TS_W'(SYNC_STAGES);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q, prev_d;
        logic [DROP_W-1:0]      drop_q, drop_d;
        logic                   rise_w, live_w, take_w, full_w;

`ifdef PTT_DEADTIME_EN
        localparam int DEAD_W = dead_w(DEAD_CYC);
        logic [DEAD_W-1:0] dead_q, dead_d;

        always_comb begin
            dead_d = dead_q;
            if (take_w) begin
                dead_d = DEAD_W'(DEAD_CYC);
            end else if (dead_q != '0) begin
                dead_d = dead_q - DEAD_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                dead_q <= '0;
            end else begin
                dead_q <= dead_d;
            end
        end

        assign live_w = (dead_q == '0);
`else
        assign live_w = 1'b1;
`endif

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], det_w[ch]};
            prev_d = sync_q[SYNC_STAGES-1];
            rise_w = sync_q[SYNC_STAGES-1] & ~prev_q;
            take_w = rise_w & enable & live_w;
            drop_d = drop_q;
            if (take_w && full_w && !(&drop_q)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                sync_q <= '0;
                prev_q <= 1'b0;
                drop_q <= '0;
            end else begin
                sync_q <= sync_d;
                prev_q <= prev_d;
                drop_q <= drop_d;
            end
        end

        ptt_tag_fifo #(
            .WIDTH (TS_W),
            .AW    (FIFO_AW)
        ) u_fifo (
            .clk       (clk),
            .RST       (RST),
            .push      (take_w),
            .push_data (tag_w),
            .full      (full_w),
            .out_data  (ts_w[ch]),
            .out_v     (v_w[ch]),
            .out_r     (rdy_w[ch])
        );

        assign drop_w[ch] = drop_q;
    end

    assign ts1   = ts_w[0];
    assign ts2   = ts_w[1];
    assign ts1_v = v_w[0];
    assign ts2_v = v_w[1];
    assign drop1 = drop_w[0];
    assign drop2 = drop_w[1];
    assign wrap  = wrap_q;

endmodule
`default_nettype wire
